branch_predict_bht: RTL and testbench

- IF-side branch direction predictor: a direct-mapped table of 2-bit saturating counters, indexed by the fetch PC.
- Produces a taken/not-taken guess for each fetched conditional branch.
- Carries that guess alongside the instruction into ID. In ID it compares the guess with the resolved Branch outcome from the branch tester.
- Trains the counter and raises a one-cycle mispredict/redirect to the PC mux and the IF/ID flush logic.

---
 rtl/branch_predict_bht.sv | 96 +++++++++
 tb/tb_branch_predict_bht.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_bht.sv
// IF-side branch direction predictor: 2-bit saturating counters in a direct-mapped table, trained from ID.
// Prediction and redirect are 0-cycle combinational; training is visible to IF one cycle after resolve.
module branch_predict_bht #(
  parameter int         IDX_BITS = 4,
  parameter logic [1:0] INIT_CNT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic        if_is_branch,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_resolve,
  input  logic        id_taken,
  output logic        pred_taken,
  output logic        mispredict,
  output logic        redirect_taken,
  output logic [31:0] br_count,
  output logic [31:0] miss_count
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]          r_table [ENTRIES];
  logic                r_id_valid;
  logic                r_id_pred;
  logic [IDX_BITS-1:0] r_id_idx;
  logic [31:0]         r_br_count;
  logic [31:0]         r_miss_count;

  logic [IDX_BITS-1:0] w_if_idx;
  logic                w_resolve_ok;
  logic [1:0]          w_cnt_cur;
  logic [1:0]          w_cnt_nxt;
  logic                w_unused_pc;

  assign w_if_idx    = if_pc[IDX_BITS+1:2];
  assign w_unused_pc = ^{if_pc[31:IDX_BITS+2], if_pc[1:0]};

  // Asynchronous read, no bypass: a same-cycle write to this index shows up next cycle.
  assign pred_taken = if_valid & if_is_branch & r_table[w_if_idx][1];

  // A resolve under stall means operands are not final yet, so it is ignored.
  assign w_resolve_ok   = id_resolve & r_id_valid & ~stall;
  assign mispredict     = w_resolve_ok & (id_taken != r_id_pred);
  assign redirect_taken = mispredict & id_taken;

  assign w_cnt_cur = r_table[r_id_idx];

  always_comb begin
    w_cnt_nxt = w_cnt_cur;
    if (id_taken) begin
      if (w_cnt_cur != 2'b11) w_cnt_nxt = w_cnt_cur + 2'd1;
    end else begin
      if (w_cnt_cur != 2'b00) w_cnt_nxt = w_cnt_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_table[i] <= INIT_CNT;
    end else if (w_resolve_ok) begin
      r_table[r_id_idx] <= w_cnt_nxt;
    end
  end

  // ID tracking: the instruction in IF is wrong-path whenever ID redirects or is flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_valid <= 1'b0;
      r_id_pred  <= 1'b0;
      r_id_idx   <= '0;
    end else if (flush || mispredict) begin
      r_id_valid <= 1'b0;
    end else if (!stall) begin
      r_id_valid <= if_valid & if_is_branch;
      r_id_pred  <= pred_taken;
      r_id_idx   <= w_if_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_count   <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_resolve_ok) r_br_count   <= r_br_count + 32'd1;
      if (mispredict)   r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign br_count   = r_br_count;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_branch_predict_bht.sv
// Bench for branch_predict_bht: reference model feeds a scoreboard queue; directed plan steps plus random traffic.
module tb_branch_predict_bht;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        if_is_branch;
  logic        stall;
  logic        flush;
  logic        id_resolve;
  logic        id_taken;
  logic        pred_taken;
  logic        mispredict;
  logic        redirect_taken;
  logic [31:0] br_count;
  logic [31:0] miss_count;

  branch_predict_bht #(.IDX_BITS(4), .INIT_CNT(2'b01)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_is_branch(if_is_branch),
    .stall(stall), .flush(flush), .id_resolve(id_resolve), .id_taken(id_taken),
    .pred_taken(pred_taken), .mispredict(mispredict), .redirect_taken(redirect_taken),
    .br_count(br_count), .miss_count(miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        pred;
    logic        mis;
    logic        redir;
    logic [31:0] br;
    logic [31:0] miss;
  } exp_t;

  exp_t sb_q[$];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  bit [1:0]  m_tbl [16];
  bit        m_idv;
  bit        m_idp;
  bit [3:0]  m_idx;
  bit [31:0] m_br;
  bit [31:0] m_miss;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_tbl[i] = 2'b01;
    m_idv  = 1'b0;
    m_idp  = 1'b0;
    m_idx  = '0;
    m_br   = '0;
    m_miss = '0;
  endtask

  // One cycle: drive, push expected outputs, sample mid-cycle, then advance the model at the edge.
  task automatic step(input bit r, input bit v, input bit b, input logic [31:0] pc,
                      input bit st, input bit fl, input bit res, input bit tk);
    exp_t     e;
    exp_t     got_e;
    bit [3:0] ix;
    bit       ok;
    @(negedge clk);
    rst = r; if_valid = v; if_is_branch = b; if_pc = pc;
    stall = st; flush = fl; id_resolve = res; id_taken = tk;
    ix      = pc[5:2];
    ok      = res & m_idv & ~st;
    e.pred  = v & b & m_tbl[ix][1];
    e.mis   = ok & (tk != m_idp);
    e.redir = e.mis & tk;
    e.br    = m_br;
    e.miss  = m_miss;
    sb_q.push_back(e);
    #2;
    got_e = sb_q.pop_front();
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, got_e.pred});
    if (!r) begin
      chk("mispredict", {31'd0, mispredict}, {31'd0, got_e.mis});
      chk("redirect", {31'd0, redirect_taken}, {31'd0, got_e.redir});
    end
    chk("br_count", br_count, got_e.br);
    chk("miss_count", miss_count, got_e.miss);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (ok) begin
        if (tk) m_tbl[m_idx] = (m_tbl[m_idx] == 2'd3) ? 2'd3 : m_tbl[m_idx] + 2'd1;
        else    m_tbl[m_idx] = (m_tbl[m_idx] == 2'd0) ? 2'd0 : m_tbl[m_idx] - 2'd1;
        m_br = m_br + 1;
        if (e.mis) m_miss = m_miss + 1;
      end
      if (fl | e.mis) m_idv = 1'b0;
      else if (!st) begin
        m_idv = v & b;
        m_idp = e.pred;
        m_idx = ix;
      end
    end
    cyc++;
  endtask

  task automatic fetch(input logic [31:0] pc);
    step(0, 1, 1, pc, 0, 0, 0, 0);
  endtask

  task automatic resolve(input bit tk);
    step(0, 0, 0, 32'h0, 0, 0, 1, tk);
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_is_branch = 1'b0;
    stall = 1'b0; flush = 1'b0; id_resolve = 1'b0; id_taken = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state
    step(0, 0, 0, 32'h0, 0, 0, 0, 0);

    // Plan 1: first fetch predicts not-taken, resolve taken redirects, refetch predicts taken
    fetch(32'h100);
    resolve(1);
    fetch(32'h100);
    #1;
    chk("t1_br", br_count, 32'd1);
    chk("t1_miss", miss_count, 32'd1);

    // Plan 2: saturate at 3, then one not-taken keeps prediction taken
    resolve(1);
    for (int k = 0; k < 4; k++) begin
      fetch(32'h100);
      resolve(1);
    end
    fetch(32'h100);
    resolve(0);
    fetch(32'h100);
    #1;
    chk("t2_pred_after_nt", {31'd0, pred_taken}, 32'd1);
    chk("t2_miss", miss_count, 32'd2);
    resolve(0);
    fetch(32'h100);
    #1;
    chk("t2_br", br_count, 32'd8);
    chk("t2_miss2", miss_count, 32'd3);

    // Plan 3: resolve held off by stall for two cycles
    fetch(32'h108);
    step(0, 1, 1, 32'h300, 1, 0, 1, 1);
    step(0, 1, 1, 32'h300, 1, 0, 1, 1);
    #1;
    chk("t3_br_stalled", br_count, 32'd8);
    step(0, 0, 0, 32'h0, 0, 0, 1, 1);
    #1;
    chk("t3_br", br_count, 32'd9);
    chk("t3_miss", miss_count, 32'd4);

    // Plan 4: wrong-path branch behind a mispredict is never trained
    fetch(32'h210);
    step(0, 1, 1, 32'h214, 0, 0, 1, 1);
    resolve(1);
    #1;
    chk("t4_br", br_count, 32'd10);
    chk("t4_miss", miss_count, 32'd5);

    // Plan 5: aliasing 0x100/0x140 and read-before-write on the same index
    fetch(32'h100);
    resolve(1);
    fetch(32'h100);
    resolve(1);
    fetch(32'h140);
    resolve(0);
    fetch(32'h100);
    step(0, 1, 1, 32'h140, 0, 0, 1, 0);
    fetch(32'h140);

    // Plan 6: reset during a mispredicting resolve
    fetch(32'h100);
    step(1, 0, 0, 32'h0, 0, 0, 1, 1);
    step(0, 0, 0, 32'h0, 0, 0, 0, 0);
    #1;
    chk("t6_br", br_count, 32'd0);
    chk("t6_miss", miss_count, 32'd0);
    for (int i = 0; i < 16; i++) begin
      fetch(32'(i * 4));
      resolve(1);
      fetch(32'(i * 4));
    end

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 149) == 0), 1'($urandom), 1'($urandom),
           {$urandom_range(0, 63), 2'b00},
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
           1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
